// File: rtl/irq_pkg.sv
// Purpose : shared types and constants for the interrupt controller.
// Contents: FSM state enum, bus data width, claim-valid bit position,
//           maximum source count and the source-ID width helper.
package irq_pkg;

  localparam int unsigned BUS_DATA_W      = 32;
  localparam int unsigned CLAIM_VALID_BIT = 31;
  localparam int unsigned MAX_SRC         = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ASSERT     = 2'd1,
    ST_IN_SERVICE = 2'd2
  } irq_state_e;

  // Source-ID width; never narrower than one bit so a single source still has an ID field.
  function automatic int unsigned id_width(input int unsigned num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Purpose : peripheral bus bundle (AS_L/WE_L strobe protocol with per-register selects).
// Signals : WE_L, AS_L            - active-low write and address strobes
//           pending/enable/claim  - register selects
//           data_in / data_out    - 32-bit write and registered read data
// Modports: master drives strobes and write data; slave returns read data.
interface irq_controller_if;

  logic                           WE_L;
  logic                           AS_L;
  logic                           pending_reg_select;
  logic                           enable_reg_select;
  logic                           claim_reg_select;
  logic [irq_pkg::BUS_DATA_W-1:0] data_in;
  logic [irq_pkg::BUS_DATA_W-1:0] data_out;

  modport master (
    output WE_L, AS_L, pending_reg_select, enable_reg_select, claim_reg_select, data_in,
    input  data_out
  );

  modport slave (
    input  WE_L, AS_L, pending_reg_select, enable_reg_select, claim_reg_select, data_in,
    output data_out
  );

endinterface

// File: rtl/prio_enc.sv
// Purpose : combinational fixed-priority encoder, lowest set index wins.
// Ports   : i_req     - request vector
//           o_id_c    - index of the lowest set request (0 when none)
//           o_valid_c - at least one request is set
module prio_enc #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic [ID_W-1:0]    o_id_c,
  output logic               o_valid_c
);

  // Scan from the top down so the last hit, the lowest index, is what remains.
  always_comb begin
    o_id_c    = '0;
    o_valid_c = 1'b0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id_c    = ID_W'(i);
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Purpose : fixed-priority interrupt controller. Captures falling edges of
//           active-low source lines into PENDING, masks with ENABLE, and drives
//           one active-low interrupt to the CPU with a claim/complete handshake.
// Ports   : clk     - system clock, rising edge
//           reset   - synchronous, active-high
//           bus     - peripheral bus slave (PENDING / ENABLE / CLAIM registers)
//           irq_n   - per-source active-low interrupt lines, synchronous to clk
//           irq_out - registered active-low interrupt to the CPU
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic                clk,
  input  logic                reset,
  irq_controller_if.slave     bus,
  input  logic [NUM_SRC-1:0]  irq_n,
  output logic                irq_out
);

  localparam int unsigned ID_W   = id_width(NUM_SRC);
  localparam int unsigned DATA_W = BUS_DATA_W;

  logic [NUM_SRC-1:0] r_irq_n_q;
  logic               r_as_l_q;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [ID_W-1:0]    r_active_id;
  irq_state_e         r_state;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_irq_out;

  logic [NUM_SRC-1:0] w_fall;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_pend_clr;
  logic [NUM_SRC-1:0] w_pend_next;
  logic [ID_W-1:0]    w_cand_id;
  logic               w_cand_valid;
  logic               w_start;
  logic               w_rd;
  logic               w_wr_start;
  logic               w_claim_rd_start;
  logic               w_claim_grant;
  logic               w_complete;
  logic [DATA_W-1:0]  w_claim_word;
  logic [DATA_W-1:0]  w_rd_data;
  logic               w_unused_ok;

  // Edge detect: one pending event per high-to-low transition.
  assign w_fall = r_irq_n_q & ~irq_n;
  assign w_req  = r_pending & r_enable;

  prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .i_req     (w_req),
    .o_id_c    (w_cand_id),
    .o_valid_c (w_cand_valid)
  );

  // Bus decode: side effects only on the first cycle of an AS_L-low access.
  assign w_start          = ~bus.AS_L & r_as_l_q;
  assign w_rd             = ~bus.AS_L & bus.WE_L;
  assign w_wr_start       = w_start & ~bus.WE_L;
  assign w_claim_rd_start = w_start & bus.WE_L & bus.claim_reg_select;
  assign w_claim_grant    = w_claim_rd_start & w_cand_valid & (r_state != ST_IN_SERVICE);
  assign w_complete       = w_wr_start & bus.claim_reg_select &
                            (bus.data_in[ID_W-1:0] == r_active_id);

  assign w_claim_word = DATA_W'(w_cand_id) | (DATA_W'(1) << CLAIM_VALID_BIT);

  // Pending clear sources: W1C write and a granted claim. New edges override clears.
  always_comb begin
    w_pend_clr = '0;
    if (w_wr_start && bus.pending_reg_select) begin
      w_pend_clr = bus.data_in[NUM_SRC-1:0];
    end
    if (w_claim_grant) begin
      w_pend_clr = w_pend_clr | (NUM_SRC'(1) << w_cand_id);
    end
    w_pend_next = (r_pending & ~w_pend_clr) | w_fall;
  end

  // Read mux; a claim read past its start cycle keeps the previously returned word.
  always_comb begin
    w_rd_data = r_data_out;
    if (bus.claim_reg_select) begin
      if (w_start) begin
        w_rd_data = w_claim_grant ? w_claim_word : '0;
      end
    end else if (bus.pending_reg_select) begin
      w_rd_data = DATA_W'(r_pending);
    end else if (bus.enable_reg_select) begin
      w_rd_data = DATA_W'(r_enable);
    end else begin
      w_rd_data = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_n_q  <= '1;
      r_as_l_q   <= 1'b1;
      r_pending  <= '0;
      r_enable   <= '0;
      r_data_out <= '0;
    end else begin
      r_irq_n_q <= irq_n;
      r_as_l_q  <= bus.AS_L;
      r_pending <= w_pend_next;
      if (w_wr_start && bus.enable_reg_select) begin
        r_enable <= bus.data_in[NUM_SRC-1:0];
      end
      if (w_rd) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  // Interrupt FSM; a granted claim moves straight to service so no second claim can win.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_irq_out   <= 1'b1;
      r_active_id <= '0;
    end else begin
      if (w_claim_grant) begin
        r_active_id <= w_cand_id;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_claim_grant) begin
            r_state   <= ST_IN_SERVICE;
            r_irq_out <= 1'b1;
          end else if (w_cand_valid) begin
            r_state   <= ST_ASSERT;
            r_irq_out <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (w_claim_grant) begin
            r_state   <= ST_IN_SERVICE;
            r_irq_out <= 1'b1;
          end else if (!w_cand_valid) begin
            r_state   <= ST_IDLE;
            r_irq_out <= 1'b1;
          end
        end
        ST_IN_SERVICE: begin
          if (w_complete) begin
            r_state   <= ST_IDLE;
            r_irq_out <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_irq_out <= 1'b1;
        end
      endcase
    end
  end

  assign bus.data_out = r_data_out;
  assign irq_out      = r_irq_out;

  // Upper write-data bits beyond the source count carry no meaning.
  assign w_unused_ok = &{1'b0, bus.data_in};

endmodule

// File: tb/tb_irq_controller.sv
// Purpose : self-checking bench for irq_controller. Directed scenarios followed by
//           a randomized phase, all compared against a behavioural model that
//           tracks pending/enable sets and a busy flag at transaction level.
module tb_irq_controller;

  localparam int unsigned NSRC = 8;
  localparam int          SEL_PEND  = 0;
  localparam int          SEL_EN    = 1;
  localparam int          SEL_CLAIM = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_n;
  logic            irq_out;

  irq_controller_if bus();

  irq_controller #(.NUM_SRC(NSRC)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq_n   (irq_n),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [NSRC-1:0] m_pending = '0;
  logic [NSRC-1:0] m_enable  = '0;
  logic [NSRC-1:0] m_prev    = '1;
  logic [NSRC-1:0] m_clr     = '0;
  logic            m_busy    = 1'b0;
  int              m_active  = 0;

  function automatic int lowest(input logic [NSRC-1:0] v);
    for (int i = 0; i < int'(NSRC); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One clock: model applies edge events, pending clears and reset; sample #1 after the edge.
  task automatic step();
    if (reset) begin
      m_pending = '0;
      m_enable  = '0;
      m_busy    = 1'b0;
      m_active  = 0;
      m_prev    = '1;
    end else begin
      m_pending = (m_pending & ~m_clr) | (m_prev & ~irq_n);
      m_prev    = irq_n;
    end
    m_clr = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.AS_L               = 1'b1;
    bus.WE_L               = 1'b1;
    bus.pending_reg_select = 1'b0;
    bus.enable_reg_select  = 1'b0;
    bus.claim_reg_select   = 1'b0;
    bus.data_in            = '0;
  endtask

  task automatic sel_reg(input int sel);
    bus.pending_reg_select = (sel == SEL_PEND);
    bus.enable_reg_select  = (sel == SEL_EN);
    bus.claim_reg_select   = (sel == SEL_CLAIM);
  endtask

  task automatic bus_wr(input int sel, input logic [31:0] d);
    sel_reg(sel);
    bus.AS_L    = 1'b0;
    bus.WE_L    = 1'b0;
    bus.data_in = d;
    case (sel)
      SEL_PEND: m_clr    = d[NSRC-1:0];
      SEL_EN:   m_enable = d[NSRC-1:0];
      default:  if (m_busy && int'(d[2:0]) == m_active) m_busy = 1'b0;
    endcase
    step();
    bus_idle();
    step();
  endtask

  // Expected claim word; a successful claim consumes the winner and marks the model busy.
  task automatic claim_expect(output logic [31:0] exp);
    int id;
    id = lowest(m_pending & m_enable);
    if (!m_busy && id >= 0) begin
      exp       = 32'h8000_0000 | 32'(id);
      m_clr[id] = 1'b1;
      m_busy    = 1'b1;
      m_active  = id;
    end else begin
      exp = 32'h0;
    end
  endtask

  task automatic rd_chk(input string tag, input int sel);
    logic [31:0] exp;
    case (sel)
      SEL_PEND: exp = 32'(m_pending);
      SEL_EN:   exp = 32'(m_enable);
      default:  claim_expect(exp);
    endcase
    sel_reg(sel);
    bus.AS_L = 1'b0;
    bus.WE_L = 1'b1;
    step();
    check(tag, bus.data_out, exp);
    bus_idle();
    step();
  endtask

  function automatic logic exp_irq();
    return (!m_busy && (m_pending & m_enable) != '0) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk_irq(input string tag);
    step();
    step();
    check(tag, 32'(irq_out), 32'(exp_irq()));
  endtask

  initial begin
    logic [31:0] exp;

    reset = 1'b1;
    irq_n = '1;
    bus_idle();
    step();
    step();
    reset = 1'b0;

    // Reset values
    check("rst irq_out", 32'(irq_out), 32'h1);
    rd_chk("rst pending", SEL_PEND);
    rd_chk("rst enable", SEL_EN);
    rd_chk("rst claim", SEL_CLAIM);

    // Basic claim/complete with a held-low source
    bus_wr(SEL_EN, 32'h04);
    irq_n[2] = 1'b0;
    step();
    check("edge t irq_out", 32'(irq_out), 32'h1);
    step();
    check("edge t+1 irq_out", 32'(irq_out), 32'h0);
    rd_chk("basic pending", SEL_PEND);
    rd_chk("basic claim", SEL_CLAIM);
    check("basic claimed irq_out", 32'(irq_out), 32'h1);
    rd_chk("basic pending cleared", SEL_PEND);
    bus_wr(SEL_CLAIM, 32'd2);
    chk_irq("held low no retrigger");

    // Priority and deferral
    bus_wr(SEL_EN, 32'hFF);
    irq_n[5] = 1'b0;
    irq_n[1] = 1'b0;
    step();
    chk_irq("prio irq_out");
    rd_chk("prio claim 1", SEL_CLAIM);
    bus_wr(SEL_CLAIM, 32'd1);
    check("deferred irq_out", 32'(irq_out), 32'h0);
    rd_chk("prio claim 5", SEL_CLAIM);
    bus_wr(SEL_CLAIM, 32'd5);

    // Masking and W1C
    irq_n = '1;
    step();
    bus_wr(SEL_EN, 32'h0);
    irq_n[3] = 1'b0;
    chk_irq("masked irq_out");
    rd_chk("masked pending", SEL_PEND);
    bus_wr(SEL_EN, 32'h08);
    check("unmask irq_out", 32'(irq_out), 32'h0);
    bus_wr(SEL_PEND, 32'h08);
    check("w1c irq_out", 32'(irq_out), 32'h1);
    rd_chk("w1c pending", SEL_PEND);

    // Multi-cycle claim strobe and wrong-ID complete
    irq_n = '1;
    step();
    bus_wr(SEL_EN, 32'hFF);
    irq_n[4] = 1'b0;
    irq_n[6] = 1'b0;
    chk_irq("two src irq_out");
    claim_expect(exp);
    sel_reg(SEL_CLAIM);
    bus.AS_L = 1'b0;
    bus.WE_L = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("held claim cyc%0d", k), bus.data_out, exp);
    end
    bus_idle();
    step();
    rd_chk("held claim pending", SEL_PEND);
    check("in service irq_out", 32'(irq_out), 32'h1);
    bus_wr(SEL_CLAIM, 32'd3);
    check("wrong id irq_out", 32'(irq_out), 32'h1);
    rd_chk("claim in service", SEL_CLAIM);
    rd_chk("wrong id pending", SEL_PEND);
    bus_wr(SEL_CLAIM, 32'd4);
    check("after complete 4 irq_out", 32'(irq_out), 32'h0);
    rd_chk("claim 6", SEL_CLAIM);
    bus_wr(SEL_CLAIM, 32'd6);

    // Set/clear collision
    irq_n = '1;
    step();
    bus_wr(SEL_EN, 32'h0);
    irq_n[0] = 1'b0;
    bus_wr(SEL_PEND, 32'h01);
    rd_chk("collision pending", SEL_PEND);
    bus_wr(SEL_PEND, 32'h01);
    rd_chk("collision cleared", SEL_PEND);

    // Randomized traffic against the model
    irq_n = '1;
    step();
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0, 1: begin
          irq_n = irq_n ^ NSRC'($urandom);
          step();
        end
        2: bus_wr(SEL_EN, $urandom);
        3: rd_chk("rnd claim", SEL_CLAIM);
        4: begin
          if (m_busy && $urandom_range(0, 3) != 0) bus_wr(SEL_CLAIM, 32'(m_active));
          else bus_wr(SEL_CLAIM, $urandom);
        end
        5: bus_wr(SEL_PEND, $urandom);
        default: rd_chk("rnd pending", SEL_PEND);
      endcase
      chk_irq("rnd irq_out");
    end
    rd_chk("rnd final enable", SEL_EN);

    // Reset while in service
    irq_n = '1;
    step();
    if (m_busy) bus_wr(SEL_CLAIM, 32'(m_active));
    bus_wr(SEL_PEND, 32'hFFFF_FFFF);
    bus_wr(SEL_EN, 32'hFF);
    irq_n[7] = 1'b0;
    step();
    step();
    rd_chk("pre-reset claim 7", SEL_CLAIM);
    irq_n = '1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("mid rst irq_out", 32'(irq_out), 32'h1);
    rd_chk("mid rst pending", SEL_PEND);
    rd_chk("mid rst enable", SEL_EN);
    rd_chk("mid rst claim", SEL_CLAIM);
    bus_wr(SEL_CLAIM, 32'd7);
    chk_irq("mid rst stale complete");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
